// File: rtl/axis_stream_arbiter.sv
// Round-robin AXI-Stream arbiter: NUM_PORTS sources share one registered sink, with bounded bursts and a source-index tag.
// Optional macro AXIS_ARB_PORT0_PRIORITY_EN makes port 0 win every arbitration it takes part in.
module axis_stream_arbiter #(
   parameter  int NUM_PORTS  = 4,
   parameter  int DATA_WIDTH = 512,
   parameter  int MAX_BURST  = 16,
   localparam int ID_WIDTH   = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [ID_WIDTH-1:0]             m_axis_tid,
   output logic                            busy
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t              state, state_nxt;
   logic [ID_WIDTH-1:0] grant, last_grant, sel;
   logic [CNT_W-1:0]    beat_cnt;
   logic                accept, last_beat;

   assign accept    = (state == GRANT) && s_axis_tvalid[grant] && s_axis_tready[grant];
   assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

   // First requester after last_grant, wrapping modulo NUM_PORTS.
   always_comb begin
      logic                found;
      logic [ID_WIDTH-1:0] cand;
      sel   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = ID_WIDTH'((int'(last_grant) + k) % NUM_PORTS);
         if (!found && s_axis_tvalid[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
`ifdef AXIS_ARB_PORT0_PRIORITY_EN
      if (s_axis_tvalid[0]) sel = '0;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|s_axis_tvalid) state_nxt = GRANT;
         GRANT:   if (!s_axis_tvalid[grant] || (accept && last_beat)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Ready is combinational from m_axis_tready so a drain and a load can share a cycle.
   always_comb begin
      s_axis_tready = '0;
      if (state == GRANT) s_axis_tready[grant] = !m_axis_tvalid || m_axis_tready;
      busy = (state == GRANT) || m_axis_tvalid;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant      <= '0;
         last_grant <= ID_WIDTH'(NUM_PORTS - 1);
         beat_cnt   <= '0;
      end else if (state == IDLE && |s_axis_tvalid) begin
         grant      <= sel;
         last_grant <= sel;
         beat_cnt   <= '0;
      end else if (accept) begin
         beat_cnt   <= beat_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tid    <= '0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tid    <= grant;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_stream_arbiter.sv
// Scoreboard bench for axis_stream_arbiter: directed source queues, expected beats queued by the stimulus, monitor pops on handshake.
module tb_axis_stream_arbiter;
   localparam int NP = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic               clk = 1'b0;
   logic               reset_n;
   logic [NP-1:0]      s_axis_tvalid, s_axis_tready;
   logic [NP*DW-1:0]   s_axis_tdata;
   logic               m_axis_tvalid, m_axis_tready;
   logic [DW-1:0]      m_axis_tdata;
   logic [1:0]         m_axis_tid;
   logic               busy;

   axis_stream_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tid(m_axis_tid), .busy(busy)
   );

   always #5 clk = ~clk;

   int          vectors = 0, miscompares = 0, cyc = 0;
   logic [DW-1:0] src_q[NP][$];
   logic [17:0] exp_q[$];
   int          out_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic src(input int p, input logic [DW-1:0] d);
      src_q[p].push_back(d);
   endtask

   task automatic exp_beat(input int p, input logic [DW-1:0] d);
      exp_q.push_back({2'(p), d});
   endtask

   task automatic timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: wait expired, got no event expected one (cycle %0d)", name, cyc);
   endtask

   task automatic wait_drain(input string name);
      logic empty;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #3;
         empty = 1'b1;
         for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) empty = 1'b0;
         if (empty && exp_q.size() == 0 && !busy) return;
      end
      timeout(name);
   endtask

   task automatic wait_out(input string name, input logic [DW-1:0] d);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (m_axis_tvalid && m_axis_tdata == d) return;
      end
      timeout(name);
   endtask

   // Source model: a beat leaves its queue only after a handshake seen at the negedge.
   initial begin
      logic [NP-1:0] acc;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      forever begin
         @(negedge clk);
         acc = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         if (!reset_n) acc = '0;
         #2;
         for (int i = 0; i < NP; i++) begin
            if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
            s_axis_tvalid[i] = (src_q[i].size() != 0);
            s_axis_tdata[i*DW +: DW] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
         end
      end
   end

   // Monitor: every output handshake is matched against the head of the expected queue.
   initial begin
      logic [17:0] e;
      forever begin
         @(negedge clk);
         if (reset_n && m_axis_tvalid && m_axis_tready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_beat: got tid %0d data %0h expected no beat", m_axis_tid, m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat_tid", 32'(m_axis_tid), 32'(e[17:16]));
               chk("beat_data", 32'(m_axis_tdata), 32'(e[15:0]));
            end
         end
      end
   end

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: got no finish expected one within time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      m_axis_tready = 1'b1;
      @(negedge clk);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_m_tdata", 32'(m_axis_tdata), 0);
      chk("rst_m_tid", 32'(m_axis_tid), 0);
      chk("rst_s_tready", 32'(s_axis_tready), 0);
      chk("rst_busy", 32'(busy), 0);
      @(posedge clk); #1 reset_n = 1'b1;

      // Single source, three beats; one arbitration cycle, then back-to-back output
      out_cyc.delete();
      @(posedge clk); #1;
      for (int b = 0; b < 3; b++) begin src(2, 16'(16'hA0 + b)); exp_beat(2, 16'(16'hA0 + b)); end
      @(negedge clk);
      chk("t1_idle_ready", 32'(s_axis_tready), 0);
      @(negedge clk);
      chk("t1_grant_ready", 32'(s_axis_tready), 32'b0100);
      wait_drain("t1_drain");
      chk("t1_beats", out_cyc.size(), 3);
      if (out_cyc.size() == 3) chk("t1_back_to_back", out_cyc[2] - out_cyc[0], 2);

      // All ports busy: bursts of MB with one bubble between bursts
      reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      out_cyc.delete();
      for (int p = 0; p < NP; p++)
         for (int b = 0; b < MB; b++) begin
            src(p, 16'(16'h100 * (p + 1) + b));
            exp_beat(p, 16'(16'h100 * (p + 1) + b));
         end
      wait_drain("t2_drain");
      chk("t2_beats", out_cyc.size(), 16);
      if (out_cyc.size() == 16) begin
         chk("t2_bubble", out_cyc[4] - out_cyc[3], 2);
         chk("t2_span", out_cyc[15] - out_cyc[0], 18);
      end

      // Output stall holds data and blocks the granted source
      for (int b = 0; b < 4; b++) begin src(1, 16'(16'hB0 + b)); exp_beat(1, 16'(16'hB0 + b)); end
      wait_out("t3_first_beat", 16'hB0);
      m_axis_tready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("t3_stall_ready", 32'(s_axis_tready), 0);
         chk("t3_stall_valid", 32'(m_axis_tvalid), 1);
         chk("t3_stall_data", 32'(m_axis_tdata), 32'hB0);
         chk("t3_stall_tid", 32'(m_axis_tid), 1);
      end
      @(posedge clk); #1 m_axis_tready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("t3_resume_ready", 32'(s_axis_tready), 32'b0010);
      end
      wait_drain("t3_drain");

      // Reset mid-burst drops the registered beat; port 0 wins afterwards
      for (int b = 0; b < 4; b++) src(3, 16'(16'hC0 + b));
      exp_beat(3, 16'hC0);
      wait_out("t4_second_beat", 16'hC1);
      reset_n = 1'b0;
      #1;
      chk("t4_rst_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("t4_rst_s_tready", 32'(s_axis_tready), 0);
      chk("t4_rst_busy", 32'(busy), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      src(0, 16'hD0);
      exp_beat(0, 16'hD0);
      exp_beat(3, 16'hC2);
      exp_beat(3, 16'hC3);
      wait_drain("t4_drain");

      // Ports 0 and 1 request together with last_grant = 0
      src(0, 16'hE0); exp_beat(0, 16'hE0);
      wait_drain("t5_setup");
      src(0, 16'hF0);
      src(1, 16'hF1);
`ifdef AXIS_ARB_PORT0_PRIORITY_EN
      exp_beat(0, 16'hF0); exp_beat(1, 16'hF1);
`else
      exp_beat(1, 16'hF1); exp_beat(0, 16'hF0);
`endif
      wait_drain("t5_drain");

      // Port 0 runs dry mid-burst while port 2 waits
      src(0, 16'h60); src(0, 16'h61);
      exp_beat(0, 16'h60); exp_beat(0, 16'h61);
      wait_out("t6_first_beat", 16'h60);
      src(2, 16'h70); src(2, 16'h71);
      exp_beat(2, 16'h70); exp_beat(2, 16'h71);
      repeat (4) @(posedge clk);
      #1;
      src(0, 16'h62);
      exp_beat(0, 16'h62);
      wait_drain("t6_drain");
      @(negedge clk);
      chk("final_m_tvalid", 32'(m_axis_tvalid), 0);
      chk("final_exp_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/axis_stream_arbiter.md
Name: axis_stream_arbiter

Overview:
- Round-robin arbiter that shares one AXI-Stream sink among NUM_PORTS requesters, e.g. several producers feeding one axis_clock_converter s_axis port.
- Grants one port at a time and holds the grant for a bounded burst.
- Drives a registered output stage and tags each output beat with the source port index.
- Single clock domain; clock crossing is done downstream.

Parameters:
- NUM_PORTS, 4, number of requesting AXIS slave ports (2..16)
- DATA_WIDTH, 512, tdata width per port
- MAX_BURST, 16, maximum beats accepted per grant before forced re-arbitration (>=1)
- ID_WIDTH (localparam), $clog2(NUM_PORTS), width of m_axis_tid

Ports:
- clk  input  1  single clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- s_axis_tvalid  input  NUM_PORTS  per-port valid; bit i belongs to port i
- s_axis_tready  output  NUM_PORTS  per-port ready; one-hot or zero
- s_axis_tdata  input  NUM_PORTS*DATA_WIDTH  port i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- m_axis_tvalid  output  1  output beat valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  DATA_WIDTH  output beat data
- m_axis_tid  output  ID_WIDTH  index of the port that supplied the current beat
- busy  output  1  high while state is GRANT or the output register is full

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0
  - s_axis_tready=0, busy=0
  - beat_cnt=0, last_grant=NUM_PORTS-1, so port 0 wins first
- Reset asserted mid-burst: all state is cleared immediately and any beat in the output register is dropped. Upstream sources keep their data, since tready was never seen with tvalid.
- States:
  - IDLE: if any s_axis_tvalid bit is set, select the first requesting port searching from last_grant+1 upward modulo NUM_PORTS. Next cycle: state=GRANT, grant=that index, last_grant=that index, beat_cnt=0. Arbitration costs one cycle; no beat is accepted in IDLE.
  - GRANT:
    - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready); this path is combinational from m_axis_tready.
    - All other ready bits are 0.
    - A beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]; beat_cnt increments on acceptance.
  - GRANT -> IDLE when either:
    - (a) a beat is accepted with beat_cnt==MAX_BURST-1, or
    - (b) s_axis_tvalid[grant]==0 in any GRANT cycle, meaning the source ran dry and no beat was taken that cycle.
- Output register:
  - Loads on every accepted beat: m_axis_tvalid<=1, m_axis_tdata<=selected data, m_axis_tid<=grant.
  - Clears m_axis_tvalid on m_axis_tready with no new load.
  - A simultaneous drain and load keeps tvalid=1 with the new beat, giving full throughput (1 beat/cycle).
- Latency: 1 cycle from acceptance to appearance on m_axis.
- A stalled m_axis_tready holds m_axis_tdata/tid stable (AXIS rule). The grant is not revoked while stalled, and beat_cnt does not advance.
- Fairness: a continuously requesting port waits at most (NUM_PORTS-1)*(MAX_BURST+1) cycles plus output stall cycles.
- Single requester: after each burst it is re-granted through IDLE; the bubble is 1 cycle per MAX_BURST beats.
- MAX_BURST=1: strict per-beat round-robin, maximum 50% throughput.
- Source dropping tvalid mid-grant is legal. Grant is released and the port rejoins arbitration normally.

Optional Feature:
- Macro AXIS_ARB_PORT0_PRIORITY_EN.
- Defined: in IDLE, port 0 wins whenever s_axis_tvalid[0]=1, regardless of last_grant. When port 0 is not requesting, the remaining ports use round-robin as above. Bursts are never preempted mid-grant; port 0 waits for the current grant to end.
- Undefined: pure round-robin as specified.

Test Plan:
- Reset, then port 2 alone sends 3 beats (0xA0,0xA1,0xA2) with m_axis_tready=1 -> grant the cycle after valid; m_axis emits 0xA0..0xA2 with tid=2 back-to-back, 1 cycle after each acceptance; GRANT->IDLE when tvalid drops; busy falls after the last drain.
- All 4 ports continuously valid, MAX_BURST=4 -> tid sequence 0,0,0,0,1,1,1,1,2,...,3,0 with exactly one bubble cycle between bursts.
- Port 1 granted, m_axis_tready=0 for 5 cycles after the first beat -> s_axis_tready[1]=0 during the stall; m_axis_tdata/tid held constant; beat_cnt unchanged; streaming resumes when ready returns.
- Port 3 granted, reset_n pulsed low for 1 cycle after beat 2 of 4 -> m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, port 0 is granted first if requesting (last_grant=NUM_PORTS-1).
- Ports 0 and 1 requesting, last_grant=0, AXIS_ARB_PORT0_PRIORITY_EN defined -> port 0 granted next. Without the macro, port 1 is granted.
- Port 0 drops tvalid mid-burst while port 2 requests -> grant moves to port 2 after one IDLE cycle; no beat from port 0 is duplicated or lost.
